// File: rtl/id_exe_hazard_ctrl_pkg.sv
// Shared constants for the ID/EXE hazard controller: operand selects,
// FSM encoding and the register address width.
package id_exe_hazard_ctrl_pkg;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned SEL_W  = 2;
    localparam int unsigned CNT_W  = 2;

    localparam logic [SEL_W-1:0] SEL_RF  = 2'b00;
    localparam logic [SEL_W-1:0] SEL_EXE = 2'b01;
    localparam logic [SEL_W-1:0] SEL_MEM = 2'b10;
    localparam logic [SEL_W-1:0] SEL_IMM = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LDSTALL = 2'd1,
        ST_FLUSH   = 2'd2
    } state_t;

endpackage

// File: rtl/id_exe_hazard_ctrl_fwd_select.sv
// Operand source comparator: picks immediate, EXE forward, MEM forward or
// register file for one ALU operand. EXE wins over MEM; r0 never forwards.
module id_exe_hazard_ctrl_fwd_select
    import id_exe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned AW = 5
) (
    input  logic [AW-1:0]    src,
    input  logic             use_src,
    input  logic             use_imm,
    input  logic [AW-1:0]    ex_rd,
    input  logic             ex_wreg,
    input  logic [AW-1:0]    mem_rd,
    input  logic             mem_wreg,
    output logic [SEL_W-1:0] sel
);

    logic src_live;

    assign src_live = use_src & (src != '0);

    // Priority select: immediate, then youngest producer, then register file
    always_comb begin
        sel = SEL_RF;
        if (use_imm) begin
            sel = SEL_IMM;
        end else if (src_live & ex_wreg & (ex_rd == src)) begin
            sel = SEL_EXE;
        end else if (src_live & mem_wreg & (mem_rd == src)) begin
            sel = SEL_MEM;
        end
    end

endmodule

// File: rtl/id_exe_hazard_ctrl.sv
// ID/EXE pipeline sequencer: bubble insertion, forwarding selects and
// front-end stall/flush for load-use hazards, taken branches and fetch stalls.
// Tracks EXE/MEM destinations locally so only the branch outcome feeds back.
module id_exe_hazard_ctrl
    import id_exe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW       = id_exe_hazard_ctrl_pkg::REG_AW,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_use_imm,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_wreg,
    input  logic              id_m2reg,
    input  logic              id_wmem,
    input  logic              id_wz,
    input  logic              exe_branch_taken,
    input  logic              ext_stall,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              if_id_flush,
    output logic              id_exe_write_en,
    output logic              ctl_wreg,
    output logic              ctl_wmem,
    output logic              ctl_wz,
    output logic              ctl_m2reg,
    output logic [1:0]        a_ctrl,
    output logic [1:0]        b_ctrl,
    output logic [1:0]        state_o
);

    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(FLUSH_CYCLES - 1);

    state_t            state;
    state_t            state_nx;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nx;

    // Shadow of the destination info now in EXE and MEM. The MEM load flag
    // is not kept: MEM forwarding already covers load data.
    logic [REG_AW-1:0] sh_ex_rd;
    logic              sh_ex_wreg;
    logic              sh_ex_m2reg;
    logic [REG_AW-1:0] sh_mem_rd;
    logic              sh_mem_wreg;

    logic              load_use;
    logic              run_hazard;
    logic              bubble;
    logic [SEL_W-1:0]  sel_a;
    logic [SEL_W-1:0]  sel_b;

    id_exe_hazard_ctrl_fwd_select #(.AW(REG_AW)) u_fwd_a (
        .src      (id_rs),
        .use_src  (id_use_rs),
        .use_imm  (1'b0),
        .ex_rd    (sh_ex_rd),
        .ex_wreg  (sh_ex_wreg),
        .mem_rd   (sh_mem_rd),
        .mem_wreg (sh_mem_wreg),
        .sel      (sel_a)
    );

    id_exe_hazard_ctrl_fwd_select #(.AW(REG_AW)) u_fwd_b (
        .src      (id_rt),
        .use_src  (id_use_rt),
        .use_imm  (id_use_imm),
        .ex_rd    (sh_ex_rd),
        .ex_wreg  (sh_ex_wreg),
        .mem_rd   (sh_mem_rd),
        .mem_wreg (sh_mem_wreg),
        .sel      (sel_b)
    );

    // Load in EXE whose result the ID instruction needs next cycle
    always_comb begin
        load_use = sh_ex_m2reg & sh_ex_wreg & (sh_ex_rd != '0) &
                   ((id_use_rs & (sh_ex_rd == id_rs)) |
                    (id_use_rt & (sh_ex_rd == id_rt)));
        run_hazard = (state == ST_RUN) & load_use;
        bubble     = ~clrn | run_hazard | (state == ST_FLUSH) |
                     ext_stall | exe_branch_taken;
    end

    // FSM state and flush counter register
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= ST_RUN;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next-state logic; a taken branch overrides every other transition
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            ST_RUN: begin
                if (exe_branch_taken) begin
                    state_nx = ST_FLUSH;
                    cnt_nx   = CNT_RELOAD;
                end else if (load_use) begin
                    state_nx = ST_LDSTALL;
                end
            end
            ST_LDSTALL: begin
                if (exe_branch_taken) begin
                    state_nx = ST_FLUSH;
                    cnt_nx   = CNT_RELOAD;
                end else if (!ext_stall) begin
                    state_nx = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (exe_branch_taken) begin
                    cnt_nx = CNT_RELOAD;
                end else if (cnt == '0) begin
                    state_nx = ST_RUN;
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nx = ST_RUN;
                cnt_nx   = '0;
            end
        endcase
    end

    // Front-end controls, gated ID/EXE control fields and operand selects
    always_comb begin
        pc_en           = ~clrn | ~(ext_stall | (run_hazard & ~exe_branch_taken));
        if_id_en        = pc_en;
        if_id_flush     = clrn & (exe_branch_taken | (state == ST_FLUSH));
        id_exe_write_en = 1'b1;
        ctl_wreg        = id_wreg  & ~bubble;
        ctl_wmem        = id_wmem  & ~bubble;
        ctl_wz          = id_wz    & ~bubble;
        ctl_m2reg       = id_m2reg & ~bubble;
        a_ctrl          = bubble ? SEL_RF : sel_a;
        b_ctrl          = bubble ? SEL_RF : sel_b;
        state_o         = state;
    end

    // Shadow pipeline: whatever enters ID/EXE this cycle is in EXE next cycle
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            sh_ex_rd    <= '0;
            sh_ex_wreg  <= 1'b0;
            sh_ex_m2reg <= 1'b0;
            sh_mem_rd   <= '0;
            sh_mem_wreg <= 1'b0;
        end else begin
            sh_mem_rd   <= sh_ex_rd;
            sh_mem_wreg <= sh_ex_wreg;
            sh_ex_rd    <= id_rd;
            sh_ex_wreg  <= ctl_wreg;
            sh_ex_m2reg <= ctl_m2reg;
        end
    end

endmodule

// File: tb/tb_id_exe_hazard_ctrl.sv
// Self-checking bench for id_exe_hazard_ctrl: directed hazard scenarios then
// randomized traffic, all compared against a pipeline-level reference model.
module tb_id_exe_hazard_ctrl;

    localparam int unsigned FC = 2;

    logic       clk;
    logic       clrn;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       id_use_rs, id_use_rt, id_use_imm;
    logic       id_wreg, id_m2reg, id_wmem, id_wz;
    logic       exe_branch_taken, ext_stall;
    logic       pc_en, if_id_en, if_id_flush, id_exe_write_en;
    logic       ctl_wreg, ctl_wmem, ctl_wz, ctl_m2reg;
    logic [1:0] a_ctrl, b_ctrl, state_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       clrn;
        logic [4:0] rs, rt, rd;
        logic       use_rs, use_rt, use_imm;
        logic       wreg, m2reg, wmem, wz;
        logic       br, stall;
    } in_t;

    typedef struct {
        logic [4:0] rd;
        logic       wreg;
        logic       m2reg;
    } ent_t;

    // Reference model: pipe[0] is the instruction in EXE, pipe[1] in MEM
    ent_t pipe [2];
    bit   in_ldstall;
    int   flush_left;

    id_exe_hazard_ctrl #(.REG_AW(5), .FLUSH_CYCLES(FC)) dut (
        .clk              (clk),
        .clrn             (clrn),
        .id_rs            (id_rs),
        .id_rt            (id_rt),
        .id_use_rs        (id_use_rs),
        .id_use_rt        (id_use_rt),
        .id_use_imm       (id_use_imm),
        .id_rd            (id_rd),
        .id_wreg          (id_wreg),
        .id_m2reg         (id_m2reg),
        .id_wmem          (id_wmem),
        .id_wz            (id_wz),
        .exe_branch_taken (exe_branch_taken),
        .ext_stall        (ext_stall),
        .pc_en            (pc_en),
        .if_id_en         (if_id_en),
        .if_id_flush      (if_id_flush),
        .id_exe_write_en  (id_exe_write_en),
        .ctl_wreg         (ctl_wreg),
        .ctl_wmem         (ctl_wmem),
        .ctl_wz           (ctl_wz),
        .ctl_m2reg        (ctl_m2reg),
        .a_ctrl           (a_ctrl),
        .b_ctrl           (b_ctrl),
        .state_o          (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic in_t op(input logic [4:0] rs, input logic [4:0] rt,
                               input logic urs, input logic urt, input logic imm,
                               input logic [4:0] rd, input logic wreg, input logic m2reg);
        in_t s;
        s.clrn = 1'b1; s.rs = rs; s.rt = rt; s.use_rs = urs; s.use_rt = urt;
        s.use_imm = imm; s.rd = rd; s.wreg = wreg; s.m2reg = m2reg;
        s.wmem = 1'b0; s.wz = 1'b0; s.br = 1'b0; s.stall = 1'b0;
        return s;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) pipe[k] = '{rd: 5'd0, wreg: 1'b0, m2reg: 1'b0};
        in_ldstall = 1'b0;
        flush_left = 0;
    endfunction

    // Youngest in-flight writer of r supplies the operand; r0 is hardwired
    function automatic logic [1:0] ref_sel(input logic used, input logic [4:0] r);
        if (!used || r == 5'd0) return 2'd0;
        for (int k = 0; k < 2; k++)
            if (pipe[k].wreg && pipe[k].rd == r) return 2'(k + 1);
        return 2'd0;
    endfunction

    task automatic run_op(input in_t s);
        logic       running, hazard, kill, exp_pc, exp_fl;
        logic [3:0] exp_ctl;
        logic [1:0] exp_a, exp_b, exp_st;
        @(posedge clk);
        #1;
        clrn = s.clrn; id_rs = s.rs; id_rt = s.rt; id_rd = s.rd;
        id_use_rs = s.use_rs; id_use_rt = s.use_rt; id_use_imm = s.use_imm;
        id_wreg = s.wreg; id_m2reg = s.m2reg; id_wmem = s.wmem; id_wz = s.wz;
        exe_branch_taken = s.br; ext_stall = s.stall;
        #3;
        if (!s.clrn) model_reset();
        running = !in_ldstall && flush_left == 0;
        hazard  = pipe[0].m2reg && pipe[0].wreg && pipe[0].rd != 5'd0 &&
                  ((s.use_rs && s.rs == pipe[0].rd) || (s.use_rt && s.rt == pipe[0].rd));
        kill    = !s.clrn || (running && hazard) || flush_left > 0 || s.stall || s.br;
        exp_pc  = !s.clrn || !(s.stall || (running && hazard && !s.br));
        exp_fl  = s.clrn && (s.br || flush_left > 0);
        exp_ctl = kill ? 4'd0 : {s.wreg, s.wmem, s.wz, s.m2reg};
        exp_a   = kill ? 2'd0 : ref_sel(s.use_rs, s.rs);
        exp_b   = kill ? 2'd0 : (s.use_imm ? 2'd3 : ref_sel(s.use_rt, s.rt));
        exp_st  = in_ldstall ? 2'd1 : (flush_left > 0 ? 2'd2 : 2'd0);
        chk("pc_en",    8'(pc_en), 8'(exp_pc));
        chk("if_id_en", 8'(if_id_en), 8'(exp_pc));
        chk("flush",    8'(if_id_flush), 8'(exp_fl));
        chk("wr_en",    8'(id_exe_write_en), 8'd1);
        chk("ctl",      8'({ctl_wreg, ctl_wmem, ctl_wz, ctl_m2reg}), 8'(exp_ctl));
        chk("a_ctrl",   8'(a_ctrl), 8'(exp_a));
        chk("b_ctrl",   8'(b_ctrl), 8'(exp_b));
        chk("state",    8'(state_o), 8'(exp_st));
        // Advance the model to what the next clock edge produces
        if (!s.clrn) begin
            model_reset();
        end else begin
            pipe[1] = pipe[0];
            pipe[0] = '{rd: s.rd, wreg: exp_ctl[3], m2reg: exp_ctl[0]};
            if (s.br) begin
                flush_left = FC;
                in_ldstall = 1'b0;
            end else if (flush_left > 0) begin
                flush_left--;
            end else if (in_ldstall) begin
                in_ldstall = s.stall;
            end else if (hazard) begin
                in_ldstall = 1'b1;
            end
        end
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) run_op(op(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0));
    endtask

    in_t s;
    in_t lw3, add6;

    initial begin
        model_reset();
        clrn = 1'b0; id_rs = '0; id_rt = '0; id_rd = '0;
        id_use_rs = 1'b0; id_use_rt = 1'b0; id_use_imm = 1'b0;
        id_wreg = 1'b0; id_m2reg = 1'b0; id_wmem = 1'b0; id_wz = 1'b0;
        exe_branch_taken = 1'b0; ext_stall = 1'b0;

        lw3  = op(5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b1, 1'b1);
        add6 = op(5'd3, 5'd3, 1'b1, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0);

        // Reset held with busy inputs: front end open, nothing latched
        s = op(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1);
        s.clrn = 1'b0; s.stall = 1'b1; s.br = 1'b1; s.wmem = 1'b1; s.wz = 1'b1;
        run_op(s);
        chk("rst_pc", 8'(pc_en), 8'd1);
        chk("rst_ctl", 8'({ctl_wreg, ctl_wmem, ctl_wz, ctl_m2reg}), 8'd0);
        nops(2);

        // add r3<-r1,r2 ; sub r4<-r3,r5 : EXE forward, no stall
        run_op(op(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0));
        run_op(op(5'd3, 5'd5, 1'b1, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0));
        chk("fwd_exe_a", 8'(a_ctrl), 8'd1);
        chk("fwd_exe_pc", 8'(pc_en), 8'd1);
        nops(2);

        // lw r3 ; add r6<-r3,r3 : one bubble then MEM forward
        run_op(lw3);
        run_op(add6);
        chk("ldu_bubble", 8'(ctl_wreg), 8'd0);
        chk("ldu_pc", 8'(pc_en), 8'd0);
        run_op(add6);
        chk("ldu_a", 8'(a_ctrl), 8'd2);
        chk("ldu_b", 8'(b_ctrl), 8'd2);
        chk("ldu_pc2", 8'(pc_en), 8'd1);
        nops(2);

        // Writer of r0 never forwards
        run_op(op(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1));
        run_op(op(5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0));
        chk("r0_a", 8'(a_ctrl), 8'd0);
        chk("r0_pc", 8'(pc_en), 8'd1);
        nops(2);

        // Taken branch: flush for pulse + FC cycles, then back to RUN
        s = op(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0);
        s.br = 1'b1;
        run_op(s);
        chk("br_flush0", 8'(if_id_flush), 8'd1);
        s.br = 1'b0;
        for (int i = 1; i <= int'(FC); i++) begin
            run_op(s);
            chk("br_flush", 8'(if_id_flush), 8'd1);
            chk("br_ctl", 8'(ctl_wreg), 8'd0);
        end
        run_op(s);
        chk("br_done", 8'(if_id_flush), 8'd0);
        chk("br_state", 8'(state_o), 8'd0);
        nops(2);

        // Load-use coincident with branch: branch wins, no stall
        run_op(lw3);
        s = add6;
        s.br = 1'b1;
        run_op(s);
        chk("ldbr_pc", 8'(pc_en), 8'd1);
        nops(1);
        chk("ldbr_state", 8'(state_o), 8'd2);
        nops(3);

        // Reset during an ext-stalled LDSTALL abandons the stall
        run_op(lw3);
        run_op(add6);
        s = add6;
        s.stall = 1'b1;
        run_op(s);
        chk("ldst_state", 8'(state_o), 8'd1);
        s.clrn = 1'b0;
        run_op(s);
        chk("rst_state", 8'(state_o), 8'd0);
        chk("rst_ctl2", 8'({ctl_wreg, ctl_wmem, ctl_wz, ctl_m2reg}), 8'd0);
        run_op(add6);
        chk("post_rst_a", 8'(a_ctrl), 8'd0);
        chk("post_rst_b", 8'(b_ctrl), 8'd0);
        chk("post_rst_pc", 8'(pc_en), 8'd1);

        // Randomized traffic over a small register set to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            s.clrn    = ($urandom_range(0, 199) != 0);
            s.rs      = 5'($urandom_range(0, 3));
            s.rt      = 5'($urandom_range(0, 3));
            s.rd      = 5'($urandom_range(0, 3));
            s.use_rs  = 1'($urandom_range(0, 3) != 0);
            s.use_rt  = 1'($urandom_range(0, 1));
            s.use_imm = 1'($urandom_range(0, 3) == 0);
            s.wreg    = 1'($urandom_range(0, 3) != 0);
            s.m2reg   = 1'($urandom_range(0, 2) == 0);
            s.wmem    = 1'($urandom_range(0, 4) == 0);
            s.wz      = 1'($urandom_range(0, 1));
            s.br      = 1'($urandom_range(0, 11) == 0);
            s.stall   = 1'($urandom_range(0, 7) == 0);
            run_op(s);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
